regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with a hazard scoreboard, replacing the fixed 32x32, two-read, one-write register file in the decode stage of the pipelined datapath. It provides `RD_PORTS` combinational read ports with same-cycle write bypass and two write ports (ALU and memory write-back). A per-register busy bit set at issue and cleared at write-back lets the hazard unit stall on pending producers. All state updates on the rising clock edge; reset clears everything asynchronously.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth = 2^ADDR_W
- `RD_PORTS`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, when 1 register 0 reads as zero and is never written or marked busy

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `rd_addr` in RD_PORTS*ADDR_W: read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- `rd_data` out RD_PORTS*DATA_W: read data, same packing
- `rd_busy` out RD_PORTS: pending-producer flag per read port
- `wr0_en` in 1: write port 0 enable (ALU write-back)
- `wr0_addr` in ADDR_W: write port 0 address
- `wr0_data` in DATA_W: write port 0 data
- `wr1_en` in 1: write port 1 enable (memory write-back; higher priority)
- `wr1_addr` in ADDR_W: write port 1 address
- `wr1_data` in DATA_W: write port 1 data
- `claim_en` in 1: mark destination busy (instruction issue)
- `claim_addr` in ADDR_W: destination being claimed
- `busy_count` out ADDR_W+1: number of registers currently busy

## Operation
- Storage: 2^ADDR_W x DATA_W array, plus a 2^ADDR_W busy vector and a busy_count register.
- Write: at posedge, if `wrN_en` is set, `reg[wrN_addr] <= wrN_data`. If both ports write the same address, port 1 wins. Different addresses both commit.
- Read: combinational, per port. Priority order:
  - ZERO_REG=1 and addr 0 → 0.
  - Otherwise `wr1_en` and matching address → `wr1_data`.
  - Otherwise `wr0_en` and matching address → `wr0_data`.
  - Otherwise the stored value.
- Busy update at posedge:
  - The bit for any enabled write address clears.
  - The bit for `claim_addr` sets when `claim_en` is high.
  - Claim and write to the same address in the same cycle: claim wins, bit ends at 1 (new producer).
- `rd_busy[p]` = `busy[rd_addr_p]` AND NOT (an enabled write to rd_addr_p this cycle). It is 0 for addr 0 when ZERO_REG=1. A claim in the current cycle is not visible until the next cycle.
- `busy_count` equals the population count of the busy vector. It is maintained incrementally at posedge:
  - +1 if the claim sets a bit that was 0.
  - −1 for each write port that clears a bit that was 1. Both ports to the same address count once.
  - Never underflows or overflows; max is 2^ADDR_W − ZERO_REG.
- Addr 0 with ZERO_REG=1: writes and claims are ignored, and busy_count is unaffected.
- Reset: all registers = 0, busy vector = 0, busy_count = 0. While `reset` is high, `rd_data` = 0, `rd_busy` = 0, and write/claim inputs are ignored.

## Timing
- Read latency: 0 cycles (combinational from `rd_addr` and the write/bypass inputs).
- Write visible from storage at the cycle after the edge. Via bypass it is visible in the same cycle.
- Busy set: visible one cycle after `claim_en`. Busy clear: visible in the write cycle via `rd_busy`, and from the next cycle in storage.
- `busy_count` is registered; it updates one edge after the claim or write.
- Asserting `reset` mid-cycle clears outputs immediately, without waiting for `clk`. On deassertion, the first edge with `reset` low performs normal updates.
- No combinational path from `claim_*` to any output.

## Test plan
- **Reset:** preload regs 5 and 9 with 0xDEADBEEF and claim reg 7, then pulse `reset` between clock edges → all `rd_data` = 0, `rd_busy` = 0, `busy_count` = 0 immediately. Reads of 5 and 9 stay 0 after release.
- **Bypass/priority:** `wr0` (addr 3, 0x11) and `wr1` (addr 3, 0x22) in the same cycle, with `rd_addr` port 0 = 3 → `rd_data` = 0x22 in that cycle and 0x22 from storage afterwards. Separate addresses 3/4 → both stored.
- **Zero register:** write 0xFFFFFFFF to addr 0 and claim addr 0 → reads 0, `rd_busy` = 0, `busy_count` unchanged. With ZERO_REG=0, addr 0 reads 0xFFFFFFFF.
- **Scoreboard:**
  - Claim 8 → next cycle `rd_busy` = 1 and `busy_count` = 1.
  - `wr0` to 8 → same-cycle `rd_busy` = 0 with `rd_data` bypassed; `busy_count` = 0 next cycle.
  - Claim and write 8 together → stays busy, count unchanged.
- **Count saturation:** claim every address 1..31 (ZERO_REG=1) → `busy_count` = 31. Re-claim 5 → stays 31. Two writes to distinct busy regs in one cycle → 29.
- **Parameter sweep:** DATA_W=64, ADDR_W=4, RD_PORTS=3 → independent reads on all three ports; write/read of 0x0123456789ABCDEF at addr 15 is correct.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with write bypass and a
// per-register busy scoreboard for the decode-stage hazard unit.
// Ports:
//   clk, reset               - rising-edge clock, async active-high reset
//   rd_addr / rd_data        - RD_PORTS combinational read ports, packed per port
//   rd_busy                  - per read port pending-producer flag
//   wr0_* / wr1_*            - ALU / memory write-back ports (wr1 has priority)
//   claim_en / claim_addr    - mark a destination busy at issue
//   busy_count               - registered population count of the busy vector
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_busy,
    input  logic                         wr0_en,
    input  logic [ADDR_W-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]            wr0_data,
    input  logic                         wr1_en,
    input  logic [ADDR_W-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]            wr1_data,
    input  logic                         claim_en,
    input  logic [ADDR_W-1:0]            claim_addr,
    output logic [ADDR_W:0]              busy_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CW    = ADDR_W + 1;
    localparam bit          ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CW-1:0]     busy_count_q, busy_count_d;

    // Register 0 is hard-wired when ZR, so its writes and claims are dropped here.
    logic wr0_ok, wr1_ok, claim_ok;
    assign wr0_ok   = wr0_en   && !(ZR && (wr0_addr   == '0));
    assign wr1_ok   = wr1_en   && !(ZR && (wr1_addr   == '0));
    assign claim_ok = claim_en && !(ZR && (claim_addr == '0));

    logic inc, dec0, dec1;

    // Next-state for storage, busy vector and incremental busy count.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr0_ok) begin
            regs_d[wr0_addr] = wr0_data;
            busy_d[wr0_addr] = 1'b0;
        end
        if (wr1_ok) begin
            regs_d[wr1_addr] = wr1_data;
            busy_d[wr1_addr] = 1'b0;
        end
        if (claim_ok) begin
            busy_d[claim_addr] = 1'b1;
        end
        // A write that collides with a claim does not lower the count; a
        // duplicate wr1 address is already counted by wr0.
        inc  = claim_ok && !busy_q[claim_addr];
        dec0 = wr0_ok && busy_q[wr0_addr] && !(claim_ok && (claim_addr == wr0_addr));
        dec1 = wr1_ok && busy_q[wr1_addr] && !(claim_ok && (claim_addr == wr1_addr))
                      && !(wr0_ok && (wr0_addr == wr1_addr));
        busy_count_d = busy_count_q + CW'(inc) - CW'(dec0) - CW'(dec1);
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    // Read ports: zero register, then wr1 bypass, wr0 bypass, storage.
    for (genvar p = 0; p < int'(RD_PORTS); p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              zero_hit, wr0_hit, wr1_hit;
        assign a        = rd_addr[p*ADDR_W +: ADDR_W];
        assign zero_hit = ZR && (a == '0);
        assign wr0_hit  = wr0_ok && (wr0_addr == a);
        assign wr1_hit  = wr1_ok && (wr1_addr == a);
        assign rd_data[p*DATA_W +: DATA_W] = (reset || zero_hit) ? '0 :
                                             wr1_hit ? wr1_data :
                                             wr0_hit ? wr0_data : regs_q[a];
        assign rd_busy[p] = !reset && !zero_hit && busy_q[a] && !wr0_hit && !wr1_hit;
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en = 1'b0, wr1_en = 1'b0, claim_en = 1'b0;
    logic [4:0]  wr0_addr = '0, wr1_addr = '0, claim_addr = '0;
    logic [31:0] wr0_data = '0, wr1_data = '0;
    logic [5:0]  busy_count;

    logic [63:0] z_rd_data;
    logic [1:0]  z_rd_busy;
    logic [5:0]  z_busy_count;

    logic [11:0]  w_rd_addr = '0;
    logic [191:0] w_rd_data;
    logic [2:0]   w_rd_busy;
    logic         w_wr0_en = 1'b0, w_wr1_en = 1'b0, w_claim_en = 1'b0;
    logic [3:0]   w_wr0_addr = '0, w_wr1_addr = '0, w_claim_addr = '0;
    logic [63:0]  w_wr0_data = '0, w_wr1_data = '0;
    logic [4:0]   w_busy_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_count(busy_count)
    );

    regfile_mp #(.ZERO_REG(0)) dut_z (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(z_rd_data), .rd_busy(z_rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_count(z_busy_count)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(4), .RD_PORTS(3), .ZERO_REG(1)) dut_w (
        .clk(clk), .reset(reset), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
        .wr0_en(w_wr0_en), .wr0_addr(w_wr0_addr), .wr0_data(w_wr0_data),
        .wr1_en(w_wr1_en), .wr1_addr(w_wr1_addr), .wr1_data(w_wr1_data),
        .claim_en(w_claim_en), .claim_addr(w_claim_addr), .busy_count(w_busy_count)
    );

    task automatic idle();
        wr0_en = 1'b0; wr1_en = 1'b0; claim_en = 1'b0;
        w_wr0_en = 1'b0; w_wr1_en = 1'b0; w_claim_en = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #20 reset = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", busy_count); end
        // preload 5 and 9, claim 7
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'hDEADBEEF;
        claim_en = 1'b1; claim_addr = 5'd7;
        @(negedge clk);
        idle();
        rd_addr = {5'd9, 5'd5};
        #1;
        checks++; if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin errors++; $display("FAIL preload: got %h want deadbeefdeadbeef", rd_data); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL preload_count: got %0d want 1", busy_count); end
        rd_addr = {5'd7, 5'd5};
        #1;
        checks++; if (rd_busy !== 2'b10) begin errors++; $display("FAIL preload_busy: got %b want 10", rd_busy); end
        // asynchronous reset pulse between edges, with writes/claims that must be ignored
        reset = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1234;
        claim_en = 1'b1; claim_addr = 5'd5;
        #1;
        checks++; if (rd_data !== 64'd0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy: got %b want 00", rd_busy); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_async_count: got %0d want 0", busy_count); end
        @(negedge clk);
        reset = 1'b0;
        idle();
        rd_addr = {5'd9, 5'd5};
        #1;
        checks++; if (rd_data !== 64'd0) begin errors++; $display("FAIL reset_release: got %h want 0", rd_data); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_ignored_claim: got %0d want 0", busy_count); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h22;
        rd_addr = {5'd6, 5'd3};
        #1;
        checks++; if (rd_data[31:0] !== 32'h22) begin errors++; $display("FAIL bypass_priority: got %h want 22", rd_data[31:0]); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd_data[31:0] !== 32'h22) begin errors++; $display("FAIL store_priority: got %h want 22", rd_data[31:0]); end
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h33;
        wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h44;
        rd_addr = {5'd4, 5'd3};
        #1;
        checks++; if (rd_data !== {32'h44, 32'h33}) begin errors++; $display("FAIL bypass_split: got %h want 0000004400000033", rd_data); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd_data !== {32'h44, 32'h33}) begin errors++; $display("FAIL store_split: got %h want 0000004400000033", rd_data); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
        claim_en = 1'b1; claim_addr = 5'd0;
        rd_addr = {5'd3, 5'd0};
        #1;
        checks++; if (rd_data[31:0] !== 32'd0) begin errors++; $display("FAIL zero_bypass: got %h want 0", rd_data[31:0]); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd_data[31:0] !== 32'd0) begin errors++; $display("FAIL zero_store: got %h want 0", rd_data[31:0]); end
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", rd_busy[0]); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL zero_count: got %0d want 0", busy_count); end
        checks++; if (z_rd_data[31:0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL nozero_store: got %h want ffffffff", z_rd_data[31:0]); end
        checks++; if (z_busy_count !== 6'd1) begin errors++; $display("FAIL nozero_count: got %0d want 1", z_busy_count); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        claim_en = 1'b1; claim_addr = 5'd8;
        rd_addr = {5'd3, 5'd8};
        #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL claim_same_cycle: got %b want 0", rd_busy[0]); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL claim_busy: got %b want 1", rd_busy[0]); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL claim_count: got %0d want 1", busy_count); end
        wr0_en = 1'b1; wr0_addr = 5'd8; wr0_data = 32'hAB;
        #1;
        checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wb_busy_clear: got %b want 0", rd_busy[0]); end
        checks++; if (rd_data[31:0] !== 32'hAB) begin errors++; $display("FAIL wb_bypass: got %h want ab", rd_data[31:0]); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL wb_count: got %0d want 0", busy_count); end
        claim_en = 1'b1; claim_addr = 5'd8;
        @(negedge clk);
        claim_en = 1'b1; claim_addr = 5'd8;
        wr0_en = 1'b1; wr0_addr = 5'd8; wr0_data = 32'hCD;
        #1;
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL reclaim_count: got %0d want 1", busy_count); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL claim_wins: got %b want 1", rd_busy[0]); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL claim_wins_count: got %0d want 1", busy_count); end
        checks++; if (rd_data[31:0] !== 32'hCD) begin errors++; $display("FAIL claim_wr_data: got %h want cd", rd_data[31:0]); end
    endtask

    task automatic test_saturation();
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            claim_en = 1'b1; claim_addr = 5'(a);
        end
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_count !== 6'd31) begin errors++; $display("FAIL sat_full: got %0d want 31", busy_count); end
        claim_en = 1'b1; claim_addr = 5'd5;
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_count !== 6'd31) begin errors++; $display("FAIL sat_reclaim: got %0d want 31", busy_count); end
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'h1;
        wr1_en = 1'b1; wr1_addr = 5'd20; wr1_data = 32'h2;
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_count !== 6'd29) begin errors++; $display("FAIL sat_dual_wb: got %0d want 29", busy_count); end
        wr0_en = 1'b1; wr0_addr = 5'd11; wr0_data = 32'h3;
        wr1_en = 1'b1; wr1_addr = 5'd11; wr1_data = 32'h4;
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_count !== 6'd28) begin errors++; $display("FAIL sat_same_addr: got %0d want 28", busy_count); end
    endtask

    task automatic test_params();
        @(negedge clk);
        w_wr0_en = 1'b1; w_wr0_addr = 4'd15; w_wr0_data = 64'h0123456789ABCDEF;
        w_wr1_en = 1'b1; w_wr1_addr = 4'd1;  w_wr1_data = 64'hAAAAAAAAAAAAAAAA;
        w_rd_addr = {4'd2, 4'd1, 4'd15};
        #1;
        checks++; if (w_rd_data !== {64'd0, 64'hAAAAAAAAAAAAAAAA, 64'h0123456789ABCDEF}) begin errors++; $display("FAIL wide_bypass: got %h", w_rd_data); end
        @(negedge clk);
        idle();
        w_wr0_en = 1'b1; w_wr0_addr = 4'd2; w_wr0_data = 64'h5555555555555555;
        #1;
        checks++; if (w_rd_data !== {64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA, 64'h0123456789ABCDEF}) begin errors++; $display("FAIL wide_mixed: got %h", w_rd_data); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (w_rd_data !== {64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA, 64'h0123456789ABCDEF}) begin errors++; $display("FAIL wide_store: got %h", w_rd_data); end
        checks++; if (w_busy_count !== 5'd0) begin errors++; $display("FAIL wide_count: got %0d want 0", w_busy_count); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_saturation();
        test_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
